// File: rtl/approx_mult_error_sweeper.sv
// Error-characterisation sweeper around the 4x4 approximate multiplier: issues every (A,B) pair
// in a programmed rectangle and accumulates error count, sum/max error distance and bias.

module multiplier_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [3:0] pp [4];
    logic       c0, c1, c2, c2p, c6;
    logic [2:0] c3_sum;
    logic [1:0] c3, c4, c5;

    always_comb begin
        for (int j = 0; j < 4; j++) begin
            pp[j] = a & {4{b[j]}};
        end
    end

    // Columns 1-2 are OR-compressed, a1*b1 is promoted to weight 8 as a carry guess,
    // column 3 saturates at 3, and columns 4-6 are exact.
    assign c0     = pp[0][0];
    assign c1     = pp[0][1] | pp[1][0];
    assign c2     = pp[0][2] | pp[2][0];
    assign c2p    = pp[1][1];
    assign c3_sum = {2'b0, pp[0][3]} + {2'b0, pp[1][2]} + {2'b0, pp[2][1]} + {2'b0, pp[3][0]};
    assign c3     = (c3_sum > 3'd3) ? 2'd3 : c3_sum[1:0];
    assign c4     = {1'b0, pp[1][3]} + {1'b0, pp[2][2]} + {1'b0, pp[3][1]};
    assign c5     = {1'b0, pp[2][3]} + {1'b0, pp[3][2]};
    assign c6     = pp[3][3];

    assign p = {7'b0, c0} + {6'b0, c1, 1'b0} + {5'b0, c2, 2'b0} + {4'b0, c2p, 3'b0}
             + {3'b0, c3, 3'b0} + {2'b0, c4, 4'b0} + {1'b0, c5, 5'b0} + {1'b0, c6, 6'b0};
endmodule

module approx_mult_error_sweeper #(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned ACC_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        a_min,
    input  logic [3:0]        a_max,
    input  logic [3:0]        b_min,
    input  logic [3:0]        b_max,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic [8:0]        pair_cnt,
    output logic [8:0]        err_cnt,
    output logic [ACC_W-1:0]  sum_ed,
    output logic [7:0]        max_ed,
    output logic [16:0]       bias
);
    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e state_q, state_d;
    logic [3:0] a_max_q, b_min_q, b_max_q;
    logic [3:0] cur_a_q, cur_a_d, cur_b_q, cur_b_d;
    logic       load, issue, clear, flush, range_bad, last_a, last_b;
    logic       range_err_q, range_err_d;

    // vld_q[0] marks stage 1, vld_q[PIPE_DEPTH-2] marks stage 2
    logic [PIPE_DEPTH-2:0] vld_q, vld_d;
    logic [3:0]            s1_a_q, s1_b_q;
    logic [7:0]            s2_approx_q, s2_exact_q, approx;

    logic [8:0]       pair_q, pair_d, err_q, err_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [7:0]       max_q, max_d, ed;
    logic [16:0]      bias_q, bias_d;
    logic signed [8:0] diff;

    assign range_bad = (a_min > a_max) || (b_min > b_max);
    assign last_a    = (cur_a_q == a_max_q);
    assign last_b    = (cur_b_q == b_max_q);

    always_comb begin
        state_d     = state_q;
        cur_a_d     = cur_a_q;
        cur_b_d     = cur_b_q;
        range_err_d = range_err_q;
        load        = 1'b0;
        issue       = 1'b0;
        flush       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    load        = 1'b1;
                    cur_a_d     = a_min;
                    cur_b_d     = b_min;
                    range_err_d = range_bad;
                    state_d     = range_bad ? StDone : StSweep;
                end
            end
            StSweep: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end else begin
                    issue = 1'b1;
                    if (last_b) begin
                        cur_b_d = b_min_q;
                        if (last_a) state_d = StDrain;
                        else        cur_a_d = cur_a_q + 4'd1;
                    end else begin
                        cur_b_d = cur_b_q + 4'd1;
                    end
                end
            end
            StDrain: begin
                if (abort) begin
                    flush   = 1'b1;
                    state_d = StIdle;
                end else if (~|vld_q[PIPE_DEPTH-3:0]) begin
                    // The last pair is accumulated on the same edge that enters StDone.
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign clear = load;
    assign vld_d = (flush || clear) ? '0 : {vld_q[PIPE_DEPTH-3:0], issue};

    multiplier_4x4 u_mult (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (approx)
    );

    assign diff = $signed({1'b0, s2_approx_q}) - $signed({1'b0, s2_exact_q});
    assign ed   = diff[8] ? 8'(-diff) : diff[7:0];

    always_comb begin
        pair_d = pair_q;
        err_d  = err_q;
        sum_d  = sum_q;
        max_d  = max_q;
        bias_d = bias_q;
        if (clear) begin
            pair_d = '0;
            err_d  = '0;
            sum_d  = '0;
            max_d  = '0;
            bias_d = '0;
        end else if (vld_q[PIPE_DEPTH-2]) begin
            pair_d = pair_q + 9'd1;
            err_d  = err_q + {8'd0, |ed};
            sum_d  = sum_q + ACC_W'(ed);
            max_d  = (ed > max_q) ? ed : max_q;
            bias_d = bias_q + {{8{diff[8]}}, diff};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_max_q     <= '0;
            b_min_q     <= '0;
            b_max_q     <= '0;
            cur_a_q     <= '0;
            cur_b_q     <= '0;
            range_err_q <= 1'b0;
            vld_q       <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_approx_q <= '0;
            s2_exact_q  <= '0;
            pair_q      <= '0;
            err_q       <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            bias_q      <= '0;
        end else begin
            state_q     <= state_d;
            cur_a_q     <= cur_a_d;
            cur_b_q     <= cur_b_d;
            range_err_q <= range_err_d;
            vld_q       <= vld_d;
            if (load) begin
                a_max_q <= a_max;
                b_min_q <= b_min;
                b_max_q <= b_max;
            end
            if (issue) begin
                s1_a_q <= cur_a_q;
                s1_b_q <= cur_b_q;
            end
            if (vld_q[0]) begin
                s2_approx_q <= approx;
                s2_exact_q  <= {4'd0, s1_a_q} * {4'd0, s1_b_q};
            end
            pair_q <= pair_d;
            err_q  <= err_d;
            sum_q  <= sum_d;
            max_q  <= max_d;
            bias_q <= bias_d;
        end
    end

    assign busy      = (state_q == StSweep) || (state_q == StDrain);
    assign done      = (state_q == StDone);
    assign range_err = range_err_q;
    assign pair_cnt  = pair_q;
    assign err_cnt   = err_q;
    assign sum_ed    = sum_q;
    assign max_ed    = max_q;
    assign bias      = bias_q;
endmodule

// File: tb/tb_approx_mult_error_sweeper.sv
// Directed bench for approx_mult_error_sweeper: hand-computed small ranges, a full sweep against
// an independent column-rule model of the approximate multiplier, and abort/reset/ignore cases.

module tb_approx_mult_error_sweeper;
    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [3:0]  a_min, a_max, b_min, b_max;
    logic        busy, done, range_err;
    logic [8:0]  pair_cnt, err_cnt;
    logic [15:0] sum_ed;
    logic [7:0]  max_ed;
    logic [16:0] bias;

    int n_cmp = 0;
    int n_err = 0;

    approx_mult_error_sweeper #(
        .PIPE_DEPTH (3),
        .ACC_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .a_min     (a_min),
        .a_max     (a_max),
        .b_min     (b_min),
        .b_max     (b_max),
        .busy      (busy),
        .done      (done),
        .range_err (range_err),
        .pair_cnt  (pair_cnt),
        .err_cnt   (err_cnt),
        .sum_ed    (sum_ed),
        .max_ed    (max_ed),
        .bias      (bias)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Column-by-column partial-product rule of the approximate multiplier.
    function automatic int gold(input int a, input int b);
        int p = 0;
        for (int k = 0; k < 7; k++) begin
            int cnt = 0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (i + j == k && ((a >> i) & 1) == 1 && ((b >> j) & 1) == 1 &&
                        !(i == 1 && j == 1)) cnt++;
                end
            end
            if (k == 1 || k == 2) cnt = (cnt > 0) ? 1 : 0;
            if (k == 3 && cnt > 3) cnt = 3;
            p += cnt << k;
        end
        if (((a >> 1) & 1) == 1 && ((b >> 1) & 1) == 1) p += 8;
        return p;
    endfunction

    // Called at a negedge; returns at the negedge of the done cycle (or after the bound).
    task automatic run(input logic [3:0] amin, input logic [3:0] amax, input logic [3:0] bmin,
                       input logic [3:0] bmax, input int repulse, output int lat,
                       output logic busy1);
        a_min = amin; a_max = amax; b_min = bmin; b_max = bmax;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        busy1 = busy;
        while (!done && lat < 400) begin
            if (lat == repulse) begin
                start = 1'b1;
                a_min = 4'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("done_seen", int'(done), 1);
    endtask

    task automatic results(input string tag, input int p, input int e, input int s, input int m,
                           input int bs);
        chk({tag, "_pair_cnt"}, int'(pair_cnt), p);
        chk({tag, "_err_cnt"}, int'(err_cnt), e);
        chk({tag, "_sum_ed"}, int'(sum_ed), s);
        chk({tag, "_max_ed"}, int'(max_ed), m);
        chk({tag, "_bias"}, int'($signed(bias)), bs);
    endtask

    initial begin
        int   lat;
        logic busy1;
        int   g_err, g_sum, g_max, g_bias, seen;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        a_min = '0; a_max = '0; b_min = '0; b_max = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_range_err", int'(range_err), 0);
        results("rst", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3x3 -> 11
        run(4'd3, 4'd3, 4'd3, 4'd3, -1, lat, busy1);
        chk("t1_latency", lat, 4);
        chk("t1_busy_after_start", int'(busy1), 1);
        results("t1", 1, 1, 2, 2, 2);
        @(negedge clk);
        chk("t1_done_one_cycle", int'(done), 0);
        chk("t1_busy_after_done", int'(busy), 0);

        // 15x15 -> 215
        run(4'd15, 4'd15, 4'd15, 4'd15, -1, lat, busy1);
        chk("t2_latency", lat, 4);
        results("t2", 1, 1, 10, 10, -10);
        @(negedge clk);

        run(4'd2, 4'd3, 4'd2, 4'd3, -1, lat, busy1);
        chk("t3_latency", lat, 7);
        results("t3", 4, 4, 14, 4, 14);
        @(negedge clk);

        run(4'd1, 4'd1, 4'd0, 4'd1, -1, lat, busy1);
        chk("t4_latency", lat, 5);
        results("t4", 2, 0, 0, 0, 0);
        // start during the done cycle is ignored and results hold
        a_min = 4'd0; a_max = 4'd0; b_min = 4'd0; b_max = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_start_busy", int'(busy), 0);
        @(negedge clk);
        chk("done_start_no_done", int'(done), 0);
        chk("hold_pair_cnt", int'(pair_cnt), 2);

        // full rectangle vs model, with a stray start pulse mid-sweep
        g_err = 0; g_sum = 0; g_max = 0; g_bias = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int d;
                d = gold(a, b) - a * b;
                if (d != 0) g_err++;
                if (d < 0) d = -d;
                g_sum += d;
                if (d > g_max) g_max = d;
                g_bias += gold(a, b) - a * b;
            end
        end
        run(4'd0, 4'd15, 4'd0, 4'd15, 50, lat, busy1);
        chk("t5_latency", lat, 259);
        results("t5", 256, g_err, g_sum, g_max, g_bias);
        @(negedge clk);

        run(4'd5, 4'd4, 4'd0, 4'd15, -1, lat, busy1);
        chk("t6_latency", lat, 1);
        chk("t6_range_err", int'(range_err), 1);
        results("t6", 0, 0, 0, 0, 0);
        @(negedge clk);

        // abort at sweep cycle 10
        a_min = 4'd0; a_max = 4'd15; b_min = 4'd0; b_max = 4'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_before", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy_after", int'(busy), 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        run(4'd3, 4'd3, 4'd3, 4'd3, -1, lat, busy1);
        chk("post_abort_latency", lat, 4);
        chk("post_abort_range_err", int'(range_err), 0);
        results("post_abort", 1, 1, 2, 2, 2);
        @(negedge clk);

        // asynchronous reset mid-sweep
        a_min = 4'd0; a_max = 4'd15; b_min = 4'd0; b_max = 4'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_pair_cnt", int'(pair_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(4'd2, 4'd3, 4'd2, 4'd3, -1, lat, busy1);
        chk("post_rst_latency", lat, 7);
        results("post_rst", 4, 4, 14, 4, 14);
        @(negedge clk);

        // start and abort together in idle: abort wins
        a_min = 4'd1; a_max = 4'd1; b_min = 4'd1; b_max = 4'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_hold", int'(pair_cnt), 4);
        repeat (5) @(negedge clk);
        chk("start_abort_no_done", int'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
